// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: WB stage, long-latency unit and register-file write port signals
interface wb_port_arbiter_if #(parameter int XLEN = 32, parameter int ADDR_W = 5);
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_addr;
  logic [XLEN-1:0]   pipe_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_addr;
  logic [XLEN-1:0]   lu_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [XLEN-1:0]   rf_data;
  logic              stall_req;
  logic              lu_pending;
  modport slave(input pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
                output lu_ready, rf_we, rf_addr, rf_data, stall_req, lu_pending);
  modport master(output pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
                 input lu_ready, rf_we, rf_addr, rf_data, stall_req, lu_pending);
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between WB and queued long-latency results
module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave b
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [XLEN-1:0]   q_data [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [PW:0]       count;
  logic [CW-1:0]     starve_cnt;
  logic              full, empty, pipe_req, push, take_fifo, take_pipe, hit;
  assign full       = count == (PW+1)'(DEPTH);
  assign empty      = count == '0;
  assign b.lu_ready = rst_n && !full;
  assign b.lu_pending = !empty;
  assign pipe_req   = b.pipe_we && b.pipe_addr != '0;
  // x0 results are acknowledged but never queued
  assign push       = b.lu_valid && b.lu_ready && b.lu_addr != '0;
  assign take_fifo  = !empty && (b.stall_req || !pipe_req);
  assign take_pipe  = pipe_req && !b.stall_req;
  assign hit        = starve_cnt == CW'(STARVE_MAX - 1);
  always_ff @(posedge clk)
    if (push) begin
      q_addr[wp] <= b.lu_addr;
      q_data[wp] <= b.lu_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      starve_cnt  <= '0;
      b.rf_we     <= 1'b0;
      b.rf_addr   <= '0;
      b.rf_data   <= '0;
      b.stall_req <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (take_fifo) rp <= rp + 1'b1;
      count   <= count + (PW+1)'(push) - (PW+1)'(take_fifo);
      b.rf_we <= take_fifo || take_pipe;
      if (take_fifo) begin
        b.rf_addr <= q_addr[rp];
        b.rf_data <= q_data[rp];
      end else if (take_pipe) begin
        b.rf_addr <= b.pipe_addr;
        b.rf_data <= b.pipe_data;
      end
      // a non-empty FIFO not granted this cycle means the pipe took the slot
      b.stall_req <= !empty && !take_fifo && hit;
      starve_cnt  <= (empty || take_fifo || hit) ? '0 : starve_cnt + 1'b1;
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of grant order, starvation stall, backpressure and reset
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [4:0] pq[$];
  logic [4:0] lq[$];
  logic [4:0] obs[$];
  logic [4:0] exp_q[$];
  wb_port_arbiter_if #(.XLEN(32), .ADDR_W(5)) b();
  wb_port_arbiter #(.XLEN(32), .ADDR_W(5), .DEPTH(2), .STARVE_MAX(4)) dut(.clk(clk), .rst_n(rst_n), .b(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    b.pipe_we = 1'b0; b.pipe_addr = '0; b.pipe_data = '0;
    b.lu_valid = 1'b0; b.lu_addr = '0; b.lu_data = '0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic run(input string tag, input int exp_blocked, input int exp_stalls);
    int cyc = 0;
    int blocked = 0;
    int stalls = 0;
    bit pa, la, done;
    obs.delete();
    done = 0;
    while (!done && cyc < 200) begin
      b.pipe_we   = pq.size() != 0;
      b.pipe_addr = pq.size() != 0 ? pq[0] : 5'd0;
      b.pipe_data = 32'hA000_0000 | 32'(b.pipe_addr);
      b.lu_valid  = lq.size() != 0;
      b.lu_addr   = lq.size() != 0 ? lq[0] : 5'd0;
      b.lu_data   = 32'hA000_0000 | 32'(b.lu_addr);
      @(negedge clk);
      pa = b.pipe_we && !b.stall_req;
      la = b.lu_valid && b.lu_ready;
      if (b.lu_valid && !b.lu_ready) blocked++;
      if (b.stall_req) stalls++;
      tick();
      if (pa) void'(pq.pop_front());
      if (la) void'(lq.pop_front());
      if (b.rf_we) begin
        obs.push_back(b.rf_addr);
        chk({tag, "_data"}, b.rf_data, 32'hA000_0000 | 32'(b.rf_addr));
      end
      cyc++;
      done = pq.size() == 0 && lq.size() == 0 && !b.lu_pending;
    end
    idle();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_nwrites"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), i < obs.size() ? obs[i] : 5'h1f, exp_q[i]);
    chk({tag, "_blocked"}, blocked, exp_blocked);
    chk({tag, "_stalls"}, stalls, exp_stalls);
  endtask
  initial begin
    bit wr;
    idle();
    #2;
    chk("rst_rf_we", b.rf_we, 0);
    chk("rst_lu_ready", b.lu_ready, 0);
    chk("rst_lu_pending", b.lu_pending, 0);
    chk("rst_stall", b.stall_req, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("post_rst_lu_ready", b.lu_ready, 1);
    b.pipe_we = 1'b1; b.pipe_addr = 5'd5; b.pipe_data = 32'hDEADBEEF;
    tick();
    chk("t1_rf_we", b.rf_we, 1);
    chk("t1_rf_addr", b.rf_addr, 5);
    chk("t1_rf_data", b.rf_data, 32'hDEADBEEF);
    chk("t1_stall", b.stall_req, 0);
    b.pipe_addr = 5'd0; b.pipe_data = 32'h1111;
    b.lu_valid = 1'b1; b.lu_addr = 5'd0; b.lu_data = 32'h55;
    tick();
    chk("t2_rf_we", b.rf_we, 0);
    chk("t2_rf_addr_hold", b.rf_addr, 5);
    chk("t2_pending", b.lu_pending, 0);
    idle();
    tick();
    chk("t2_rf_we_b", b.rf_we, 0);
    chk("t2_pending_b", b.lu_pending, 0);
    b.lu_valid = 1'b1; b.lu_addr = 5'd7; b.lu_data = 32'h1234;
    tick();
    idle();
    chk("t3_pending", b.lu_pending, 1);
    chk("t3_rf_we_early", b.rf_we, 0);
    tick();
    chk("t3_rf_we", b.rf_we, 1);
    chk("t3_rf_addr", b.rf_addr, 7);
    chk("t3_rf_data", b.rf_data, 32'h1234);
    chk("t3_pending_clr", b.lu_pending, 0);
    pq = '{1, 2, 3, 4, 5, 6, 7, 8};
    lq = '{9};
    exp_q = '{1, 2, 3, 4, 5, 9, 6, 7, 8};
    run("t4", 0, 1);
    pq = '{20, 21, 22, 23};
    lq = '{10, 11, 12};
    exp_q = '{20, 21, 22, 23, 10, 11, 12};
    run("t5", 3, 0);
    b.pipe_we = 1'b1; b.pipe_addr = 5'd3; b.pipe_data = 32'h33;
    b.lu_valid = 1'b1; b.lu_addr = 5'd14; b.lu_data = 32'hE;
    tick();
    b.lu_addr = 5'd15; b.lu_data = 32'hF;
    tick();
    b.lu_valid = 1'b0;
    chk("t6_pending_pre", b.lu_pending, 1);
    chk("t6_ready_full", b.lu_ready, 0);
    chk("t6_rf_we_pre", b.rf_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rf_we", b.rf_we, 0);
    chk("t6_rst_rf_addr", b.rf_addr, 0);
    chk("t6_rst_rf_data", b.rf_data, 0);
    chk("t6_rst_stall", b.stall_req, 0);
    chk("t6_rst_pending", b.lu_pending, 0);
    chk("t6_rst_ready", b.lu_ready, 0);
    idle();
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("t6_pending_post", b.lu_pending, 0);
    chk("t6_ready_post", b.lu_ready, 1);
    wr = b.rf_we;
    for (int i = 0; i < 4; i++) begin
      tick();
      wr |= b.rf_we;
    end
    chk("t6_no_flushed_write", wr, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
